// File: rtl/control_unit_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle control unit:
// FSM states, instruction classes, opcodes, ALU/PC select codes and control_word bit positions.
package control_unit_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    OPC_ADD,
    OPC_SUB,
    OPC_AND,
    OPC_ORR,
    OPC_ADDI,
    OPC_SUBI,
    OPC_LDUR,
    OPC_STUR,
    OPC_B,
    OPC_CBZ
  } opclass_t;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;

  localparam logic [1:0] PS_HOLD   = 2'b00;
  localparam logic [1:0] PS_INC    = 2'b01;
  localparam logic [1:0] PS_REG    = 2'b10;
  localparam logic [1:0] PS_OFFSET = 2'b11;

  localparam logic [1:0] MEM_SZ_WORD  = 2'b10;
  localparam logic [1:0] MEM_SZ_DWORD = 2'b11;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // Immediate forms only own bits [31:22]; bit 21 belongs to imm12.
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;

  localparam int CW_WIDTH       = 37;
  localparam int CW_DA          = 0;
  localparam int CW_SA          = 5;
  localparam int CW_SB          = 10;
  localparam int CW_WR          = 15;
  localparam int CW_BSEL        = 16;
  localparam int CW_FS          = 17;
  localparam int CW_CO          = 22;
  localparam int CW_EN_B        = 23;
  localparam int CW_EN_ADDR_ALU = 24;
  localparam int CW_EN_ALU      = 25;
  localparam int CW_MEM_READ    = 26;
  localparam int CW_MEM_WRITE   = 27;
  localparam int CW_MEM_SIZE    = 28;
  localparam int CW_STATUS_LOAD = 30;
  localparam int CW_PCSEL       = 31;
  localparam int CW_EN_ADDR_PC  = 32;
  localparam int CW_EN_PC       = 33;
  localparam int CW_INSTR_LOAD  = 34;
  localparam int CW_PS          = 35;

endpackage

// File: rtl/cu_decoder.sv
// Combinational instruction classifier: opcode -> opclass, illegal flag and
// the extended immediate/branch offset the datapath will see as constant.
module cu_decoder
  import control_unit_pkg::*;
(
  input  logic [31:0] instruction,
  output opclass_t    opclass,
  output logic        illegal,
  output logic [63:0] constant
);

  always_comb begin
    opclass  = OPC_ADD;
    illegal  = 1'b0;
    constant = '0;
    if (instruction[31:21] == OP_ADD) begin
      opclass = OPC_ADD;
    end else if (instruction[31:21] == OP_SUB) begin
      opclass = OPC_SUB;
    end else if (instruction[31:21] == OP_AND) begin
      opclass = OPC_AND;
    end else if (instruction[31:21] == OP_ORR) begin
      opclass = OPC_ORR;
    end else if (instruction[31:22] == OP_ADDI) begin
      opclass  = OPC_ADDI;
      constant = {52'd0, instruction[21:10]};
    end else if (instruction[31:22] == OP_SUBI) begin
      opclass  = OPC_SUBI;
      constant = {52'd0, instruction[21:10]};
    end else if (instruction[31:21] == OP_LDUR) begin
      opclass  = OPC_LDUR;
      constant = {{55{instruction[20]}}, instruction[20:12]};
    end else if (instruction[31:21] == OP_STUR) begin
      opclass  = OPC_STUR;
      constant = {{55{instruction[20]}}, instruction[20:12]};
    end else if (instruction[31:26] == OP_B) begin
      opclass  = OPC_B;
      constant = {{36{instruction[25]}}, instruction[25:0], 2'b00};
    end else if (instruction[31:24] == OP_CBZ) begin
      opclass  = OPC_CBZ;
      constant = {{43{instruction[23]}}, instruction[23:5], 2'b00};
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/control_unit.sv
// LEGv8 fetch/decode/execute sequencer producing control_word and constant for datapath_memory.
// Define CU_PERF_CNT_EN to add retired_count / cycle_count outputs.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         instruction_reg,
  input  logic [3:0]          alu_status,
  input  logic                mem_ready,
  output logic [CW_WIDTH-1:0] control_word,
  output logic [63:0]         constant,
  output logic                halted,
`ifdef CU_PERF_CNT_EN
  output logic [31:0]         retired_count,
  output logic [31:0]         cycle_count,
`endif
  output logic                fault_timeout
);

  localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t      state, state_next;
  opclass_t    dec_opclass, opclass_q;
  logic        dec_illegal;
  logic [63:0] dec_constant, constant_q;
  logic [4:0]  rd_q, rn_q, rm_q;
  logic [TW-1:0] tmo_cnt;
  logic        mem_wait, mem_op, tmo_hit, fault_q;
  logic        unused_status;

  assign unused_status = ^alu_status[3:1];

  cu_decoder u_decoder (
    .instruction (instruction_reg),
    .opclass     (dec_opclass),
    .illegal     (dec_illegal),
    .constant    (dec_constant)
  );

  assign mem_op   = (opclass_q == OPC_LDUR) || (opclass_q == OPC_STUR);
  assign mem_wait = (state == ST_FETCH) || ((state == ST_EXEC) && mem_op);
  // Fires on the MEM_TIMEOUT-th consecutive cycle without mem_ready.
  assign tmo_hit  = (MEM_TIMEOUT != 0) && mem_wait && !mem_ready &&
                    (tmo_cnt == TW'(MEM_TIMEOUT - 1));

  always_comb begin
    state_next = state;
    case (state)
      ST_BOOT:   state_next = ST_FETCH;
      ST_FETCH:  if (mem_ready) state_next = ST_DECODE;
      ST_DECODE: state_next = dec_illegal ? ST_HALT : ST_EXEC;
      ST_EXEC:   if (!mem_op || mem_ready) state_next = ST_FETCH;
      ST_HALT:   state_next = ST_HALT;
      default:   state_next = ST_HALT;
    endcase
    if (tmo_hit) state_next = ST_HALT;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_BOOT;
      opclass_q  <= OPC_ADD;
      constant_q <= '0;
      rd_q       <= '0;
      rn_q       <= '0;
      rm_q       <= '0;
      tmo_cnt    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_DECODE) begin
        opclass_q  <= dec_opclass;
        constant_q <= dec_constant;
        rd_q       <= instruction_reg[4:0];
        rn_q       <= instruction_reg[9:5];
        rm_q       <= instruction_reg[20:16];
      end
      if (state_next != state) begin
        tmo_cnt <= '0;
      end else if (mem_wait && !mem_ready) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (tmo_hit) fault_q <= 1'b1;
    end
  end

  always_comb begin
    control_word = '0;
    constant     = '0;
    case (state)
      ST_FETCH: begin
        control_word[CW_EN_ADDR_PC]        = 1'b1;
        control_word[CW_MEM_READ]          = 1'b1;
        control_word[CW_MEM_SIZE +: 2]     = MEM_SZ_WORD;
        control_word[CW_INSTR_LOAD]        = mem_ready;
        control_word[CW_PS +: 2]           = mem_ready ? PS_INC : PS_HOLD;
      end
      ST_EXEC: begin
        constant = constant_q;
        case (opclass_q)
          OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR, OPC_ADDI, OPC_SUBI: begin
            control_word[CW_DA +: 5]  = rd_q;
            control_word[CW_SA +: 5]  = rn_q;
            control_word[CW_SB +: 5]  = rm_q;
            control_word[CW_WR]       = 1'b1;
            control_word[CW_EN_ALU]   = 1'b1;
            control_word[CW_BSEL]     = (opclass_q == OPC_ADDI) || (opclass_q == OPC_SUBI);
            case (opclass_q)
              OPC_AND: control_word[CW_FS +: 5] = FS_AND;
              OPC_ORR: control_word[CW_FS +: 5] = FS_ORR;
              OPC_SUB, OPC_SUBI: begin
                control_word[CW_FS +: 5] = FS_SUB;
                control_word[CW_CO]      = 1'b1;
              end
              default: control_word[CW_FS +: 5] = FS_ADD;
            endcase
          end
          OPC_LDUR, OPC_STUR: begin
            control_word[CW_SA +: 5]       = rn_q;
            control_word[CW_BSEL]          = 1'b1;
            control_word[CW_FS +: 5]       = FS_ADD;
            control_word[CW_EN_ADDR_ALU]   = 1'b1;
            control_word[CW_MEM_SIZE +: 2] = MEM_SZ_DWORD;
            if (opclass_q == OPC_LDUR) begin
              control_word[CW_DA +: 5]    = rd_q;
              control_word[CW_MEM_READ]   = 1'b1;
              control_word[CW_WR]         = mem_ready;
            end else begin
              control_word[CW_SB +: 5]    = rd_q;
              control_word[CW_EN_B]       = 1'b1;
              control_word[CW_MEM_WRITE]  = 1'b1;
            end
          end
          OPC_B: control_word[CW_PS +: 2] = PS_OFFSET;
          OPC_CBZ: begin
            control_word[CW_SA +: 5] = rd_q;
            control_word[CW_SB +: 5] = 5'd31;
            control_word[CW_FS +: 5] = FS_ORR;
            control_word[CW_PS +: 2] = alu_status[0] ? PS_OFFSET : PS_HOLD;
          end
          default: control_word = '0;
        endcase
      end
      default: control_word = '0;
    endcase
  end

  assign halted        = (state == ST_HALT);
  assign fault_timeout = fault_q;

`ifdef CU_PERF_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retired_count <= '0;
      cycle_count   <= '0;
    end else begin
      if ((state == ST_EXEC) && (state_next == ST_FETCH)) retired_count <= retired_count + 32'd1;
      if (state != ST_HALT) cycle_count <= cycle_count + 32'd1;
    end
  end
`endif

endmodule
